// File: rtl/mem_ctrl_pkg.sv
// Shared types, default widths and helpers for the SRAM/DDR transfer controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DATA = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } xfer_state_e;

  localparam int DEF_NUM_CLIENTS = 16;
  localparam int DEF_DDR_AW      = 32;
  localparam int DEF_SRAM_AW     = 19;
  localparam int DEF_BURST_LEN   = 16;
  localparam int DEF_LEN_W       = 12;

  function automatic int unsigned min_len(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_client_arb.sv
// Rotating-priority arbiter: first requester found searching upward from start, with wrap.
module mem_client_arb #(
  parameter int N = 16
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  logic [$clog2(N)-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    // N is a power of two, so the index add wraps for free.
    for (int i = 0; i < N; i++) begin
      j = start + ($clog2(N))'(i);
      if (en && !any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = j;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_xfer_ctrl.sv
// DDR<->SRAM burst transfer sequencer plus arbitrated single-word SRAM reads for clients.
// Handshakes: ddr_req is held with stable ddr_we/ddr_addr/ddr_burst_len until ddr_ack is
// seen high on a clock edge; afterwards each cycle with ddr_beat high moves exactly one beat.
module mem_xfer_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int DDR_AW      = DEF_DDR_AW,
  parameter int SRAM_AW     = DEF_SRAM_AW,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int LEN_W       = DEF_LEN_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cfg_start,
  input  logic                                   cfg_dir,
  input  logic [DDR_AW-1:0]                      cfg_ddr_addr,
  input  logic [SRAM_AW-1:0]                     cfg_sram_addr,
  input  logic [LEN_W-1:0]                       cfg_len,
  output logic                                   cfg_busy,
  output logic                                   cfg_done,
  output logic                                   ddr_req,
  output logic                                   ddr_we,
  output logic [DDR_AW-1:0]                      ddr_addr,
  output logic [$clog2(BURST_LEN):0]             ddr_burst_len,
  input  logic                                   ddr_ack,
  input  logic                                   ddr_beat,
  output logic                                   ddr_last,
  output logic [$clog2(BURST_LEN):0]             last_valid,
  output logic                                   sram_en,
  output logic                                   sram_we,
  output logic [SRAM_AW-1:0]                     sram_addr,
  input  logic                                   prio_mode,
  input  logic [$clog2(NUM_CLIENTS)-1:0]         prio_client,
  input  logic [NUM_CLIENTS-1:0]                 client_req,
  input  logic [NUM_CLIENTS-1:0][SRAM_AW-1:0]    client_addr,
  output logic [NUM_CLIENTS-1:0]                 client_gnt,
  output logic [NUM_CLIENTS-1:0]                 client_rvalid,
  output xfer_state_e                            dbg_state
);

  localparam int BW  = $clog2(BURST_LEN);
  localparam int BLW = BW + 1;
  localparam int CW  = $clog2(NUM_CLIENTS);

  xfer_state_e       state;
  logic [DDR_AW-1:0]  cur_ddr;
  logic [SRAM_AW-1:0] cur_sram;
  logic [LEN_W-1:0]   remaining;
  logic [BLW-1:0]     beat_cnt;
  logic [DDR_AW-1:0]  next_ddr;
  logic [BW-1:0]      lv_mod;
  logic               beat_act;

  logic [CW-1:0]          rr_ptr;
  logic [CW-1:0]          arb_start;
  logic [NUM_CLIENTS-1:0] arb_gnt;
  logic [CW-1:0]          arb_idx;
  logic                   arb_any;

  assign beat_act  = (state == DATA) && ddr_beat;
  assign next_ddr  = cur_ddr + DDR_AW'(ddr_burst_len);
  assign lv_mod    = cfg_len[BW-1:0];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_ddr       <= '0;
      cur_sram      <= '0;
      remaining     <= '0;
      beat_cnt      <= '0;
      cfg_busy      <= 1'b0;
      cfg_done      <= 1'b0;
      ddr_req       <= 1'b0;
      ddr_we        <= 1'b0;
      ddr_addr      <= '0;
      ddr_burst_len <= '0;
      last_valid    <= '0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            cur_ddr    <= cfg_ddr_addr;
            cur_sram   <= cfg_sram_addr;
            remaining  <= cfg_len;
            ddr_we     <= cfg_dir;
            cfg_busy   <= 1'b1;
            last_valid <= (lv_mod == '0) ? BLW'(BURST_LEN) : BLW'(lv_mod);
            if (cfg_len == '0) begin
              state <= DONE;
            end else begin
              state         <= REQ;
              ddr_req       <= 1'b1;
              ddr_addr      <= cfg_ddr_addr;
              ddr_burst_len <= BLW'(min_len(BURST_LEN, 32'(cfg_len)));
            end
          end
        end
        REQ: begin
          if (ddr_ack) begin
            ddr_req  <= 1'b0;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (ddr_beat) begin
            cur_sram  <= cur_sram + SRAM_AW'(1);
            remaining <= remaining - LEN_W'(1);
            beat_cnt  <= beat_cnt + BLW'(1);
            if (beat_cnt + BLW'(1) == ddr_burst_len) state <= NEXT;
          end
        end
        NEXT: begin
          cur_ddr <= next_ddr;
          if (remaining != '0) begin
            state         <= REQ;
            ddr_req       <= 1'b1;
            ddr_addr      <= next_ddr;
            ddr_burst_len <= BLW'(min_len(BURST_LEN, 32'(remaining)));
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          cfg_done <= 1'b1;
          cfg_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A DDR beat owns the SRAM port; clients only compete for the idle cycles.
  assign arb_start = prio_mode ? rr_ptr : prio_client;

  mem_client_arb #(.N(NUM_CLIENTS)) u_arb (
    .req   (client_req),
    .start (arb_start),
    .en    (!beat_act),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign client_gnt = arb_gnt;
  assign ddr_last   = beat_act && (remaining == LEN_W'(1));

  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    if (beat_act) begin
      sram_en   = 1'b1;
      sram_we   = !ddr_we;
      sram_addr = cur_sram;
    end else if (arb_any) begin
      sram_en   = 1'b1;
      sram_addr = client_addr[arb_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      client_rvalid <= '0;
    end else begin
      client_rvalid <= arb_gnt;
      if (prio_mode && arb_any) rr_ptr <= arb_idx + CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Randomized bench for mem_xfer_ctrl against a transaction-level model of bursts and accesses.
module tb_mem_xfer_ctrl;

  localparam int N   = 16;
  localparam int DAW = 32;
  localparam int SAW = 19;
  localparam int BL  = 16;
  localparam int LW  = 12;
  localparam int BLW = 5;

  logic                   clk;
  logic                   rst_n;
  logic                   cfg_start;
  logic                   cfg_dir;
  logic [DAW-1:0]         cfg_ddr_addr;
  logic [SAW-1:0]         cfg_sram_addr;
  logic [LW-1:0]          cfg_len;
  logic                   cfg_busy;
  logic                   cfg_done;
  logic                   ddr_req;
  logic                   ddr_we;
  logic [DAW-1:0]         ddr_addr;
  logic [BLW-1:0]         ddr_burst_len;
  logic                   ddr_ack;
  logic                   ddr_beat;
  logic                   ddr_last;
  logic [BLW-1:0]         last_valid;
  logic                   sram_en;
  logic                   sram_we;
  logic [SAW-1:0]         sram_addr;
  logic                   prio_mode;
  logic [3:0]             prio_client;
  logic [N-1:0]           client_req;
  logic [N-1:0][SAW-1:0]  client_addr;
  logic [N-1:0]           client_gnt;
  logic [N-1:0]           client_rvalid;
  mem_ctrl_pkg::xfer_state_e dbg_state;

  mem_xfer_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_dir       (cfg_dir),
    .cfg_ddr_addr  (cfg_ddr_addr),
    .cfg_sram_addr (cfg_sram_addr),
    .cfg_len       (cfg_len),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .ddr_req       (ddr_req),
    .ddr_we        (ddr_we),
    .ddr_addr      (ddr_addr),
    .ddr_burst_len (ddr_burst_len),
    .ddr_ack       (ddr_ack),
    .ddr_beat      (ddr_beat),
    .ddr_last      (ddr_last),
    .last_valid    (last_valid),
    .sram_en       (sram_en),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .prio_mode     (prio_mode),
    .prio_client   (prio_client),
    .client_req    (client_req),
    .client_addr   (client_addr),
    .client_gnt    (client_gnt),
    .client_rvalid (client_rvalid),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [37:0]    exp_burst_q[$];
  logic [19:0]    exp_sram_q[$];
  int             pending;
  logic [3:0]     rr_ptr_m;
  logic [N-1:0]   prev_gnt_m;
  logic [N-1:0]   exp_gnt_now;
  logic [BLW-1:0] lv_exp;
  int             done_cnt;
  int             cmd_cnt;
  int             bursts_seen;

  // stimulus knobs
  bit traffic;
  bit ack_always;
  bit beat_alt;
  int beat_pct;
  bit rand_clients;

  function automatic int pick(input logic [N-1:0] req, input int start);
    for (int i = 0; i < N; i++) begin
      if (req[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  // scoreboard / monitor
  logic        mon_beat;
  int          mon_idx;
  logic [37:0] mon_b;
  logic [19:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pending     = 0;
      prev_gnt_m  = '0;
      exp_gnt_now = '0;
      rr_ptr_m    = '0;
    end else begin
      chk("rvalid", 64'(client_rvalid), 64'(prev_gnt_m));
      mon_beat = ddr_beat && (pending > 0);
      exp_gnt_now = '0;
      if (mon_beat) begin
        chk("gnt_in_beat", 64'(client_gnt), 64'd0);
        if (exp_sram_q.size() == 0) begin
          chk("sram_unexp", 64'd1, 64'd0);
        end else begin
          mon_e = exp_sram_q.pop_front();
          chk("sram_beat_en", 64'(sram_en), 64'd1);
          chk("sram_beat_acc", 64'({sram_we, sram_addr}), 64'(mon_e));
          chk("ddr_last", 64'(ddr_last), 64'(exp_sram_q.size() == 0));
        end
        pending--;
      end else begin
        mon_idx = pick(client_req, prio_mode ? int'(rr_ptr_m) : int'(prio_client));
        if (mon_idx >= 0) exp_gnt_now[mon_idx] = 1'b1;
        chk("gnt", 64'(client_gnt), 64'(exp_gnt_now));
        chk("ddr_last_idle", 64'(ddr_last), 64'd0);
        if (mon_idx >= 0) begin
          chk("client_acc", 64'({sram_en, sram_we, sram_addr}), 64'({2'b10, client_addr[mon_idx]}));
          if (prio_mode) rr_ptr_m = 4'(mon_idx + 1);
        end else begin
          chk("sram_idle", 64'(sram_en), 64'd0);
        end
      end
      prev_gnt_m = exp_gnt_now;
      if (ddr_req && ddr_ack) begin
        bursts_seen++;
        if (exp_burst_q.size() == 0) begin
          chk("burst_unexp", 64'd1, 64'd0);
        end else begin
          mon_b = exp_burst_q.pop_front();
          chk("burst", 64'({ddr_we, ddr_addr, ddr_burst_len}), 64'(mon_b));
          pending = int'(mon_b[4:0]);
        end
      end
      if (cfg_busy) chk("last_valid", 64'(last_valid), 64'(lv_exp));
      if (cfg_done) begin
        done_cnt++;
        chk("done_early", 64'(exp_sram_q.size()), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (traffic) begin
      ddr_ack  = ack_always ? 1'b1 : 1'($urandom_range(0, 1));
      ddr_beat = beat_alt ? ~ddr_beat : ($urandom_range(0, 99) < beat_pct);
    end
    if (rand_clients) begin
      for (int i = 0; i < N; i++)
        if (!client_req[i]) client_addr[i] = SAW'($urandom);
      client_req = (client_req & ~exp_gnt_now) | N'($urandom_range(0, 65535) & $urandom_range(0, 65535));
    end
  endtask

  task automatic push_expect(input logic dir, input logic [31:0] ddr, input logic [18:0] sram,
                             input int len);
    for (int off = 0; off < len; off += BL)
      exp_burst_q.push_back({dir, ddr + 32'(off), BLW'((len - off) < BL ? (len - off) : BL)});
    for (int k = 0; k < len; k++)
      exp_sram_q.push_back({~dir, sram + 19'(k)});
    lv_exp = (len % BL == 0) ? BLW'(BL) : BLW'(len % BL);
  endtask

  task automatic run_cmd(input logic dir, input logic [31:0] ddr, input logic [18:0] sram,
                         input int len, input bit dup);
    int n;
    push_expect(dir, ddr, sram, len);
    cfg_dir       = dir;
    cfg_ddr_addr  = ddr;
    cfg_sram_addr = sram;
    cfg_len       = LW'(len);
    cfg_start     = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      cfg_start = dup && (n == 3);
      if (n == 3) begin
        cfg_dir       = ~dir;
        cfg_ddr_addr  = $urandom;
        cfg_sram_addr = SAW'($urandom);
        cfg_len       = LW'($urandom_range(1, 30));
      end
      if (n == 1) chk("busy_set", 64'(cfg_busy), 64'd1);
    end while (!cfg_done && n < 3000);
    cfg_start = 1'b0;
    cmd_cnt++;
    chk("done_seen", 64'(cfg_done), 64'd1);
    chk("busy_clear", 64'(cfg_busy), 64'd0);
    if (len == 0) chk("zero_len_latency", 64'(n), 64'd2);
    chk("bursts_left", 64'(exp_burst_q.size()), 64'd0);
    chk("sram_left", 64'(exp_sram_q.size()), 64'd0);
    step();
    chk("done_pulse", 64'(cfg_done), 64'd0);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},  64'(cfg_busy), 64'd0);
    chk({tag, "_done"},  64'(cfg_done), 64'd0);
    chk({tag, "_req"},   64'({ddr_req, ddr_we, ddr_last}), 64'd0);
    chk({tag, "_addr"},  64'(ddr_addr), 64'd0);
    chk({tag, "_blen"},  64'({ddr_burst_len, last_valid}), 64'd0);
    chk({tag, "_sram"},  64'({sram_en, sram_we, sram_addr}), 64'd0);
    chk({tag, "_cli"},   64'({client_gnt, client_rvalid}), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'(mem_ctrl_pkg::IDLE));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int n;
    total = 0; bad = 0; done_cnt = 0; cmd_cnt = 0; bursts_seen = 0;
    pending = 0; rr_ptr_m = '0; prev_gnt_m = '0; exp_gnt_now = '0; lv_exp = '0;
    traffic = 1'b0; ack_always = 1'b1; beat_alt = 1'b0; beat_pct = 100; rand_clients = 1'b0;
    rst_n = 1'b0; cfg_start = 1'b0; cfg_dir = 1'b0; cfg_ddr_addr = '0; cfg_sram_addr = '0;
    cfg_len = '0; ddr_ack = 1'b0; ddr_beat = 1'b0; prio_mode = 1'b0; prio_client = '0;
    client_req = '0;
    for (int i = 0; i < N; i++) client_addr[i] = SAW'(32'h100 + i);

    #12;
    check_all_zero("reset");
    step();
    rst_n = 1'b1;
    step();

    // round-robin sweep: everyone requesting
    prio_mode  = 1'b1;
    client_req = '1;
    for (int i = 0; i < N; i++) begin
      #1;
      chk("rr_order", 64'(client_gnt), 64'(1 << i));
      step();
    end
    #1;
    chk("rr_wrap", 64'(client_gnt), 64'd1);

    // fixed priority from client 5
    prio_mode   = 1'b0;
    prio_client = 4'd5;
    client_req  = N'((1 << 3) | (1 << 5) | (1 << 9));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fixed_gnt5", 64'(client_gnt), 64'(1 << 5));
    end
    client_req = N'((1 << 3) | (1 << 9));
    step();
    chk("fixed_gnt9", 64'(client_gnt), 64'(1 << 9));
    client_req = '0;
    step();

    // directed transfers, immediate ack, beat every cycle
    traffic = 1'b1; ack_always = 1'b1; beat_pct = 100;
    run_cmd(1'b0, 32'h1000_0000, 19'h00100, 40, 1'b0);
    run_cmd(1'b1, 32'h0000_2000, 19'h7FFFE, 16, 1'b0);
    run_cmd(1'b0, 32'h0000_3000, 19'h00000, 0, 1'b0);
    run_cmd(1'b1, 32'h0000_4000, 19'h01000, 40, 1'b1);
    run_cmd(1'b0, 32'hFFFF_FFF0, 19'h02000, 33, 1'b0);

    // clients contending with beats on alternate cycles
    prio_mode = 1'b1; beat_alt = 1'b1; rand_clients = 1'b1;
    run_cmd(1'b0, 32'h0000_5000, 19'h03000, 40, 1'b0);
    beat_alt = 1'b0;

    // reset during the second burst
    rand_clients = 1'b0; client_req = '0; beat_pct = 100;
    push_expect(1'b0, 32'h0000_6000, 19'h04000, 40);
    cfg_dir = 1'b0; cfg_ddr_addr = 32'h0000_6000; cfg_sram_addr = 19'h04000;
    cfg_len = LW'(40); cfg_start = 1'b1;
    b0 = bursts_seen;
    n = 0;
    do begin
      step();
      cfg_start = 1'b0;
      n++;
    end while (bursts_seen < b0 + 2 && n < 500);
    chk("second_burst_seen", 64'(bursts_seen), 64'(b0 + 2));
    step();
    step();
    rst_n = 1'b0;
    exp_burst_q.delete();
    exp_sram_q.delete();
    #1;
    check_all_zero("midreset");
    step();
    step();
    rst_n = 1'b1;
    step();
    run_cmd(1'b1, 32'h0000_7000, 19'h05000, 20, 1'b0);

    // randomized commands
    ack_always = 1'b0; beat_pct = 60; rand_clients = 1'b1;
    for (int c = 0; c < 14; c++) begin
      prio_mode   = 1'($urandom_range(0, 1));
      prio_client = 4'($urandom_range(0, 15));
      run_cmd(1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63)) : $urandom,
              SAW'($urandom), $urandom_range(0, 70), 1'b0);
    end

    rand_clients = 1'b0; client_req = '0;
    for (int i = 0; i < 4; i++) step();
    chk("done_count", 64'(done_cnt), 64'(cmd_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
